// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//
// Purpose:
//   Arbitrates two write requesters onto the single synchronous write port
//   of the 32x32 register file. Requester 0 is the ALU writeback path and
//   requester 1 is the multicycle/load unit. Each requester owns a one-entry
//   holding slot. Slots are drained oldest-first, and simultaneous arrivals
//   are resolved round-robin. The register file port is driven from
//   registers, so a write accepted at edge E is captured by the register
//   file at edge E+2 when there is no contention.
//
// Ports:
//   clk                      clock, all state updates on the rising edge
//   rst_n                    asynchronous active-low reset
//   reqN_valid               requester N offers a write (N = 0, 1)
//   reqN_addr                requester N destination register
//   reqN_data                requester N write data
//   reqN_ready               slot N can accept a write this cycle
//   rf_we                    register file write enable (never set for r0)
//   rf_waddr                 register file write address
//   rf_wdata                 register file write data
//   idle                     both slots empty and no write on the port

module regwrite_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  idle
);

  logic                  occ0_q, occ0_d, occ1_q, occ1_d;
  logic                  age0_q, age0_d, age1_q, age1_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  rr_q, rr_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic grant0, grant1, tie;
  logic acc0, acc1;

  // Grant selection. A set age flag means that slot was loaded before the
  // other one, so it wins; with neither flag set both slots were loaded on
  // the same edge and rr breaks the tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    tie    = 1'b0;
    if (occ0_q && occ1_q) begin
      if (age0_q) begin
        grant0 = 1'b1;
      end else if (age1_q) begin
        grant1 = 1'b1;
      end else begin
        tie    = 1'b1;
        grant0 = !rr_q;
        grant1 = rr_q;
      end
    end else begin
      grant0 = occ0_q;
      grant1 = occ1_q;
    end
  end

  // A granted slot empties this edge, so it can take a new write at once.
  assign req0_ready = !occ0_q || grant0;
  assign req1_ready = !occ1_q || grant1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  // Next-state for slots, age flags, round-robin pointer and the write port.
  // A slot becomes "older" when the other slot is loaded while it is still
  // waiting; this keeps same-address writes in acceptance order.
  always_comb begin
    occ0_d     = occ0_q;
    occ1_d     = occ1_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    age0_d     = age0_q;
    age1_d     = age1_q;
    rr_d       = tie ? !rr_q : rr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (grant0) begin
      occ0_d = 1'b0;
      age0_d = 1'b0;
    end
    if (grant1) begin
      occ1_d = 1'b0;
      age1_d = 1'b0;
    end

    if (acc0) begin
      occ0_d  = 1'b1;
      addr0_d = req0_addr;
      data0_d = req0_data;
      age0_d  = 1'b0;
      if (occ1_q && !grant1) begin
        age1_d = 1'b1;
      end
    end
    if (acc1) begin
      occ1_d  = 1'b1;
      addr1_d = req1_addr;
      data1_d = req1_data;
      age1_d  = 1'b0;
      if (occ0_q && !grant0) begin
        age0_d = 1'b1;
      end
    end

    // Writes to r0 still move the address/data registers but never strobe.
    if (grant0) begin
      rf_waddr_d = addr0_q;
      rf_wdata_d = data0_q;
      rf_we_d    = (addr0_q != '0);
    end else if (grant1) begin
      rf_waddr_d = addr1_q;
      rf_wdata_d = data1_q;
      rf_we_d    = (addr1_q != '0);
    end
  end

  // State registers; reset drops any buffered or in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ0_q     <= 1'b0;
      occ1_q     <= 1'b0;
      age0_q     <= 1'b0;
      age1_q     <= 1'b0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      rr_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      occ0_q     <= occ0_d;
      occ1_q     <= occ1_d;
      age0_q     <= age0_d;
      age1_q     <= age1_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      rr_q       <= rr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = !occ0_q && !occ1_q && !rf_we_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter
//
// Purpose:
//   Self-checking bench for regwrite_arbiter. The reference model keeps each
//   buffered write with the cycle number at which it was accepted; the
//   earliest accepted write is sent to the register file first, and writes
//   accepted on the same edge alternate between requesters.
//
// Ports: none (top-level bench).

module tb_regwrite_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          idle;

  int errors = 0;
  int checks = 0;

  regwrite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Observable outputs packed together for whole-state comparisons.
  logic [40:0] dutVec;
  assign dutVec = {rf_we, rf_waddr, rf_wdata, req0_ready, req1_ready, idle};

  // Reference model: buffered writes tagged with their acceptance cycle.
  logic          mOcc[2];
  logic [AW-1:0] mAddr[2];
  logic [DW-1:0] mData[2];
  int            mTs[2];
  logic          mRr;
  int            mCyc;
  logic          expWe;
  logic [AW-1:0] expWaddr;
  logic [DW-1:0] expWdata;
  logic          accepted[2];

  // Writes seen on the register file port.
  logic [AW-1:0] logAddr[$];
  logic [DW-1:0] logData[$];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mOcc[i] = 1'b0;
      mAddr[i] = '0;
      mData[i] = '0;
      mTs[i] = 0;
      accepted[i] = 1'b0;
    end
    mRr = 1'b0;
    expWe = 1'b0;
    expWaddr = '0;
    expWdata = '0;
  endtask

  // Which buffered write goes next: earliest acceptance first.
  function automatic int modelGrant();
    if (mOcc[0] && mOcc[1]) begin
      if (mTs[0] < mTs[1]) return 0;
      if (mTs[1] < mTs[0]) return 1;
      return mRr ? 1 : 0;
    end
    if (mOcc[0]) return 0;
    if (mOcc[1]) return 1;
    return -1;
  endfunction

  function automatic logic [40:0] expVec();
    int g;
    g = modelGrant();
    return {expWe, expWaddr, expWdata, (!mOcc[0] || g == 0),
            (!mOcc[1] || g == 1), (!mOcc[0] && !mOcc[1] && !expWe)};
  endfunction

  task automatic modelEdge();
    int g;
    logic v[2];
    logic rdy[2];
    logic [AW-1:0] ia[2];
    logic [DW-1:0] id[2];
    v[0] = req0_valid; ia[0] = req0_addr; id[0] = req0_data;
    v[1] = req1_valid; ia[1] = req1_addr; id[1] = req1_data;
    g = modelGrant();
    if (mOcc[0] && mOcc[1] && mTs[0] == mTs[1]) mRr = !mRr;
    for (int i = 0; i < 2; i++) rdy[i] = !mOcc[i] || g == i;
    if (g >= 0) begin
      expWaddr = mAddr[g];
      expWdata = mData[g];
      expWe = (mAddr[g] != '0);
      mOcc[g] = 1'b0;
    end else begin
      expWe = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      accepted[i] = v[i] && rdy[i];
      if (accepted[i]) begin
        mOcc[i] = 1'b1;
        mAddr[i] = ia[i];
        mData[i] = id[i];
        mTs[i] = mCyc;
      end
    end
    mCyc++;
  endtask

  // Drive both requesters, advance one edge, sample 1 time unit later.
  task automatic applyStimulus(input logic v0, input int a0, input logic [31:0] d0,
                               input logic v1, input int a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = AW'(a0); req0_data = d0;
    req1_valid = v1; req1_addr = AW'(a1); req1_data = d1;
    @(posedge clk);
    modelEdge();
    #1;
    if (rf_we === 1'b1) begin
      logAddr.push_back(rf_waddr);
      logData.push_back(rf_wdata);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if (dutVec !== {1'b0, 5'd0, 32'd0, 3'b111}) begin
      errors++;
      $display("[TB] FAIL reset_initial got=%h want=%h", dutVec, {1'b0, 5'd0, 32'd0, 3'b111});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if (dutVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL single_accept got=%h want=%h", dutVec, expVec());
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL single_write got=%h want=%h", {rf_we, rf_waddr, rf_wdata},
               {1'b1, 5'd5, 32'hDEADBEEF});
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_idle got=%b want=1", idle);
    end
  endtask

  task automatic test_tie();
    logic [AW-1:0] first[2];
    logic [AW-1:0] second[2];
    first[0] = 5'd3; second[0] = 5'd4;
    first[1] = 5'd4; second[1] = 5'd3;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1, 3, 32'h11, 1, 4, 32'h22);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if ({rf_we, rf_waddr} !== {1'b1, first[r]}) begin
        errors++;
        $display("[TB] FAIL tie%0d_first got=%h want=%h", r, {rf_we, rf_waddr}, {1'b1, first[r]});
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if ({rf_we, rf_waddr} !== {1'b1, second[r]}) begin
        errors++;
        $display("[TB] FAIL tie%0d_second got=%h want=%h", r, {rf_we, rf_waddr}, {1'b1, second[r]});
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL tie%0d_drain got=%h want=%h", r, dutVec, expVec());
      end
    end
  endtask

  task automatic test_ordering();
    // Cycles 0-3 make the next tie go to requester 1, so slot 0 is left
    // waiting while requester 1 refills with 0xA and then requester 0 with 0xB.
    int v0[11] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    int a0[11] = '{1, 0, 0, 0, 12, 0, 7, 0, 0, 0, 0};
    int d0[11] = '{1, 0, 0, 0, 'h12, 0, 'hB, 0, 0, 0, 0};
    int v1[11] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    int a1[11] = '{2, 0, 0, 0, 13, 7, 0, 0, 0, 0, 0};
    int d1[11] = '{2, 0, 0, 0, 'h13, 'hA, 0, 0, 0, 0, 0};
    logic [DW-1:0] seen[$];
    logAddr.delete();
    logData.delete();
    for (int k = 0; k < 11; k++) begin
      applyStimulus(v0[k][0], a0[k], d0[k], v1[k][0], a1[k], d1[k]);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL order_cyc%0d got=%h want=%h", k, dutVec, expVec());
      end
    end
    foreach (logAddr[i]) if (logAddr[i] == 5'd7) seen.push_back(logData[i]);
    checks++;
    if (seen.size() != 2 || seen[0] !== 32'hA || seen[1] !== 32'hB) begin
      errors++;
      $display("[TB] FAIL order_addr7 got=%0d writes first=%h want=2 writes A then B",
               seen.size(), (seen.size() > 0) ? seen[0] : 32'hX);
    end
  endtask

  task automatic test_regzero();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_ready got=%b want=1", req1_ready);
    end
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_we0 got=%b want=0", rf_we);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'hFFFF}) begin
      errors++;
      $display("[TB] FAIL zero_port got=%h want=%h", {rf_we, rf_waddr, rf_wdata},
               {1'b0, 5'd0, 32'hFFFF});
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if (dutVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL zero_after got=%h want=%h", dutVec, expVec());
    end
  endtask

  task automatic test_back_to_back();
    int idx[2];
    int accCount;
    int run;
    int bestRun;
    idx[0] = 0; idx[1] = 0;
    accCount = 0; run = 0; bestRun = 0;
    logAddr.delete();
    logData.delete();
    for (int k = 0; k < 14; k++) begin
      if (k < 10)
        applyStimulus(1, 8 + idx[0], 32'hA000 + idx[0], 1, 20 + idx[1], 32'hB000 + idx[1]);
      else
        applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) if (accepted[i]) begin idx[i]++; accCount++; end
      run = (rf_we === 1'b1) ? run + 1 : 0;
      if (run > bestRun) bestRun = run;
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL b2b_cyc%0d got=%h want=%h", k, dutVec, expVec());
      end
    end
    checks++;
    if (bestRun < 10) begin
      errors++;
      $display("[TB] FAIL b2b_run got=%0d want>=10", bestRun);
    end
    checks++;
    if (logAddr.size() != accCount) begin
      errors++;
      $display("[TB] FAIL b2b_count got=%0d want=%0d", logAddr.size(), accCount);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1, 9, 32'h99, 1, 10, 32'hAA);
    applyStimulus(1, 11, 32'hBB, 1, 12, 32'hCC);
    checks++;
    if ({rf_we, req0_ready & req1_ready, idle} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL rstmid_busy got=%b want=100", {rf_we, req0_ready & req1_ready, idle});
    end
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if (dutVec !== {1'b0, 5'd0, 32'd0, 3'b111}) begin
      errors++;
      $display("[TB] FAIL rstmid_async got=%h want=%h", dutVec, {1'b0, 5'd0, 32'd0, 3'b111});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    logAddr.delete();
    logData.delete();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL rstmid_after%0d got=%h want=%h", k, dutVec, expVec());
      end
    end
    checks++;
    if (logAddr.size() != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_stale got=%0d writes want=0", logAddr.size());
    end
  endtask

  task automatic test_random();
    logic pV[2];
    int pA[2];
    logic [31:0] pD[2];
    int accCount;
    pV[0] = 1'b0; pV[1] = 1'b0;
    pA[0] = 0; pA[1] = 0;
    pD[0] = 0; pD[1] = 0;
    accCount = 0;
    logAddr.delete();
    logData.delete();
    for (int k = 0; k < 400; k++) begin
      applyStimulus(pV[0], pA[0], pD[0], pV[1], pA[1], pD[1]);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL rand_cyc%0d got=%h want=%h", k, dutVec, expVec());
      end
      // A requester keeps its offer stable until the slot accepts it.
      for (int i = 0; i < 2; i++) begin
        if (accepted[i]) accCount++;
        if (accepted[i] || !pV[i]) begin
          pV[i] = ($urandom_range(0, 3) != 0);
          pA[i] = $urandom_range(0, 31);
          pD[i] = $urandom;
        end
      end
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rand_idle got=%b want=1", idle);
    end
  endtask

  initial begin
    modelReset();
    mCyc = 1;
    test_reset();
    test_single_write();
    test_tie();
    test_ordering();
    test_regzero();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
